// File: rtl/nv_nvdla_cdma_wg_fifo_arb.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cdma_wg_fifo_arb
//
// Write-side arbiter and credit scheduler for the CDMA WG 128x5 FIFO.
// Requester 0 (DC path) and requester 1 (WG path) share the single FIFO write
// port. Each word written is {src_id, payload}. Per-source occupancy is
// tracked from the pop side and gated by programmable quotas. A group that
// does not end on its first beat locks the grant to its source until the
// group's last beat, or until MAX_BURST beats, whichever comes first.
//
// Ports:
//   clk, reset_             core clock, asynchronous active-high reset
//   reqN_valid/ready/data/last  requester N beat handshake (N = 0, 1)
//   quota0, quota1          max outstanding entries per source (0 = disabled)
//   fifo_wr_req/ready/data  registered FIFO write port
//   fifo_pop, fifo_pop_src  pop handshake and source bit of popped word
//   outstanding0/1          entries accepted and not yet popped, per source
//   burst_trunc             sticky flag: a burst was force-released
//
// Optional build macro CDMA_WG_ARB_STATS_EN adds stat_clr (in) and the
// 16-bit saturating counters stat_beats0, stat_beats1 and stat_stall (out).
// -----------------------------------------------------------------------------
module nv_nvdla_cdma_wg_fifo_arb #(
  parameter int DEPTH     = 128,
  parameter int CNT_W     = 8,
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_data,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_data,
  input  logic             req1_last,
  input  logic [CNT_W-1:0] quota0,
  input  logic [CNT_W-1:0] quota1,
  output logic             fifo_wr_req,
  input  logic             fifo_wr_ready,
  output logic [DW:0]      fifo_wr_data,
  input  logic             fifo_pop,
  input  logic             fifo_pop_src,
  output logic [CNT_W-1:0] outstanding0,
  output logic [CNT_W-1:0] outstanding1,
  output logic             burst_trunc
`ifdef CDMA_WG_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_beats0,
  output logic [15:0]      stat_beats1,
  output logic [15:0]      stat_stall
`endif
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic             burst_trunc_q, burst_trunc_d;
  logic             out_vld_q, out_vld_d;
  logic [DW:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] outstanding0_q, outstanding0_d;
  logic [CNT_W-1:0] outstanding1_q, outstanding1_d;

  // ---------------------------------------------------------------------------
  // Eligibility
  // ---------------------------------------------------------------------------
  logic             stage_free;
  logic [CNT_W:0]   occ_sum;
  logic             credit_ok;
  logic             elig0, elig1;

  // The output register can take a beat when it is empty or draining now.
  assign stage_free = !out_vld_q || fifo_wr_ready;
  assign occ_sum    = {1'b0, outstanding0_q} + {1'b0, outstanding1_q};
  assign credit_ok  = occ_sum < (CNT_W+1)'(DEPTH);

  // reset_ gates eligibility so no beat is handshaken while reset is held.
  assign elig0 = !reset_ && req0_valid && (outstanding0_q < quota0) &&
                 credit_ok && stage_free;
  assign elig1 = !reset_ && req1_valid && (outstanding1_q < quota1) &&
                 credit_ok && stage_free;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      beat_cnt_q    <= '0;
      burst_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_trunc_q <= burst_trunc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (grant selection)
  // ---------------------------------------------------------------------------
  logic grant_vld;
  logic grant_src;

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_vld = 1'b1;
          grant_src = rr_ptr_q;
        end else if (elig0) begin
          grant_vld = 1'b1;
          grant_src = 1'b0;
        end else if (elig1) begin
          grant_vld = 1'b1;
          grant_src = 1'b1;
        end
      end
      // A locked source that is not eligible stalls; the other side waits.
      LOCK0: begin
        grant_vld = elig0;
        grant_src = 1'b0;
      end
      LOCK1: begin
        grant_vld = elig1;
        grant_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign req0_ready = grant_vld && !grant_src;
  assign req1_ready = grant_vld &&  grant_src;

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  logic             acc_last;
  logic [DW-1:0]    acc_data;
  logic [BC_W-1:0]  beat_next;

  assign acc_last  = grant_src ? req1_last : req0_last;
  assign acc_data  = grant_src ? req1_data : req0_data;
  // In IDLE the counter is 0, so the first beat of a group counts as 1.
  assign beat_next = beat_cnt_q + BC_W'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    burst_trunc_d = burst_trunc_q;
    if (grant_vld) begin
      if (state_q == IDLE) rr_ptr_d = !grant_src;
      if (acc_last || (beat_next == BC_W'(MAX_BURST))) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        if (!acc_last) burst_trunc_d = 1'b1;
      end else begin
        state_d    = grant_src ? LOCK1 : LOCK0;
        beat_cnt_d = beat_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage and occupancy counters
  // ---------------------------------------------------------------------------
  logic inc0, inc1, dec0, dec1;

  assign inc0 = grant_vld && !grant_src;
  assign inc1 = grant_vld &&  grant_src;
  // Pops reported against an empty count are ignored rather than wrapping.
  assign dec0 = fifo_pop && !fifo_pop_src && (outstanding0_q != '0);
  assign dec1 = fifo_pop &&  fifo_pop_src && (outstanding1_q != '0);

  always_comb begin
    out_vld_d      = out_vld_q;
    out_data_d     = out_data_q;
    if (stage_free) begin
      out_vld_d = grant_vld;
      if (grant_vld) out_data_d = {grant_src, acc_data};
    end
    outstanding0_d = outstanding0_q + CNT_W'(inc0) - CNT_W'(dec0);
    outstanding1_d = outstanding1_q + CNT_W'(inc1) - CNT_W'(dec1);
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      outstanding0_q <= '0;
      outstanding1_q <= '0;
    end else begin
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      outstanding0_q <= outstanding0_d;
      outstanding1_q <= outstanding1_d;
    end
  end

  assign fifo_wr_req  = out_vld_q;
  assign fifo_wr_data = out_data_q;
  assign outstanding0 = outstanding0_q;
  assign outstanding1 = outstanding1_q;
  assign burst_trunc  = burst_trunc_q;

`ifdef CDMA_WG_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [15:0] stat_beats0_q, stat_beats1_q, stat_stall_q;
  logic        stall;

  assign stall = out_vld_q && !fifo_wr_ready;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      stat_beats0_q <= '0;
      stat_beats1_q <= '0;
      stat_stall_q  <= '0;
    end else if (stat_clr) begin
      stat_beats0_q <= '0;
      stat_beats1_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (inc0  && (stat_beats0_q != 16'hFFFF)) stat_beats0_q <= stat_beats0_q + 16'd1;
      if (inc1  && (stat_beats1_q != 16'hFFFF)) stat_beats1_q <= stat_beats1_q + 16'd1;
      if (stall && (stat_stall_q  != 16'hFFFF)) stat_stall_q  <= stat_stall_q  + 16'd1;
    end
  end

  assign stat_beats0 = stat_beats0_q;
  assign stat_beats1 = stat_beats1_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_wg_fifo_arb.sv
// -----------------------------------------------------------------------------
// Testbench for nv_nvdla_cdma_wg_fifo_arb.
// A transaction-level model (lock owner, favoured source, per-source counts,
// one-entry output stage) predicts every output each cycle; directed phases
// add hand-computed literal expectations on word order and counters.
// -----------------------------------------------------------------------------
module tb_nv_nvdla_cdma_wg_fifo_arb;

  localparam int DEPTH     = 128;
  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       reset_ = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0;
  logic       req1_valid = 1'b0, req1_last = 1'b0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] quota0 = 8'd128, quota1 = 8'd128;
  logic       fifo_wr_req;
  logic       fifo_wr_ready = 1'b1;
  logic [4:0] fifo_wr_data;
  logic       fifo_pop = 1'b0, fifo_pop_src = 1'b0;
  logic [7:0] outstanding0, outstanding1;
  logic       burst_trunc;
`ifdef CDMA_WG_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_beats0, stat_beats1, stat_stall;
`endif

  nv_nvdla_cdma_wg_fifo_arb dut (
    .clk          (clk),
    .reset_       (reset_),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .quota0       (quota0),
    .quota1       (quota1),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_wr_ready(fifo_wr_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_pop     (fifo_pop),
    .fifo_pop_src (fifo_pop_src),
    .outstanding0 (outstanding0),
    .outstanding1 (outstanding1),
    .burst_trunc  (burst_trunc)
`ifdef CDMA_WG_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_beats0  (stat_beats0),
    .stat_beats1  (stat_beats1),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Words seen leaving the output stage, for literal order checks.
  logic [4:0] got[$];

  // ---------------------------------------------------------------------------
  // Behavioural model and per-cycle compare (sampled at the falling edge; the
  // model then advances with the values the next rising edge will sample).
  // ---------------------------------------------------------------------------
  int         m_owner;   // -1: no lock, else locked source
  int         m_beats;   // beats accepted in the current group
  int         m_fav;     // source preferred on a tie
  int         m_out[2];
  bit         m_sv;
  logic [4:0] m_sw;
  bit         m_trunc;

  always @(negedge clk) begin
    bit         v[2], l[2], can[2];
    logic [3:0] d[2];
    int         q[2];
    int         pick;
    bit         free, room;
    if (reset_) begin
      m_owner = -1; m_beats = 0; m_fav = 0;
      m_out[0] = 0; m_out[1] = 0;
      m_sv = 1'b0; m_sw = '0; m_trunc = 1'b0;
      check("rst_wr_req", fifo_wr_req, 0);
      check("rst_wr_data", fifo_wr_data, 0);
      check("rst_out0", outstanding0, 0);
      check("rst_out1", outstanding1, 0);
      check("rst_trunc", burst_trunc, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
    end else begin
      v[0] = req0_valid; v[1] = req1_valid;
      l[0] = req0_last;  l[1] = req1_last;
      d[0] = req0_data;  d[1] = req1_data;
      q[0] = int'(quota0); q[1] = int'(quota1);
      free = !m_sv || fifo_wr_ready;
      room = (m_out[0] + m_out[1]) < DEPTH;
      for (int i = 0; i < 2; i++) can[i] = v[i] && (m_out[i] < q[i]) && room && free;
      if (m_owner >= 0)        pick = can[m_owner] ? m_owner : -1;
      else if (can[0] && can[1]) pick = m_fav;
      else if (can[0])         pick = 0;
      else if (can[1])         pick = 1;
      else                     pick = -1;

      check("ready0", req0_ready, (pick == 0));
      check("ready1", req1_ready, (pick == 1));
      check("wr_req", fifo_wr_req, m_sv);
      if (m_sv) check("wr_data", fifo_wr_data, m_sw);
      check("out0", outstanding0, m_out[0]);
      check("out1", outstanding1, m_out[1]);
      check("trunc", burst_trunc, m_trunc);

      if (fifo_wr_req && fifo_wr_ready) got.push_back(fifo_wr_data);

      if (free) begin
        m_sv = (pick >= 0);
        if (pick >= 0) m_sw = {pick[0], d[pick]};
      end
      if (fifo_pop && m_out[fifo_pop_src] > 0) m_out[fifo_pop_src]--;
      if (pick >= 0) begin
        m_out[pick]++;
        if (m_owner < 0) begin
          m_fav   = 1 - pick;
          m_beats = 1;
        end else begin
          m_beats++;
        end
        if (l[pick] || m_beats == MAX_BURST) begin
          if (!l[pick]) m_trunc = 1'b1;
          m_owner = -1;
          m_beats = 0;
        end else begin
          m_owner = pick;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus driver: each source offers beats until 'limit' are accepted,
  // asserting last on every grp-th beat; payload counts per accepted beat.
  // ---------------------------------------------------------------------------
  int         limit[2], grp[2], sent[2];
  logic [3:0] dat[2];

  task automatic drive_inputs();
    req0_valid = sent[0] < limit[0];
    req1_valid = sent[1] < limit[1];
    req0_last  = ((sent[0] + 1) % grp[0]) == 0;
    req1_last  = ((sent[1] + 1) % grp[1]) == 0;
    req0_data  = dat[0];
    req1_data  = dat[1];
  endtask

  task automatic run(input int n);
    bit h0, h1;
    repeat (n) begin
      drive_inputs();
      #1;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) begin sent[0]++; dat[0] = dat[0] + 4'd1; end
      if (h1) begin sent[1]++; dat[1] = dat[1] + 4'd1; end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    reset_        = 1'b1;
    fifo_pop      = 1'b0;
    fifo_pop_src  = 1'b0;
    fifo_wr_ready = 1'b1;
    quota0        = 8'd128;
    quota1        = 8'd128;
    sent[0] = 0; sent[1] = 0;
    dat[0]  = 4'h0; dat[1] = 4'h8;
    limit[0] = 0; limit[1] = 0;
    grp[0]   = 1; grp[1]   = 1;
    drive_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    got.delete();
    reset_ = 1'b0;
  endtask

  logic [4:0] w;

  initial begin
    // Phase 1: both sources streaming single-beat groups -> strict alternation.
    do_reset();
    limit[0] = 1000; limit[1] = 1000;
    drive_inputs(); #1;
    check("p1_first_wr_req", fifo_wr_req, 0);
    check("p1_first_ready0", req0_ready, 1);
    check("p1_first_ready1", req1_ready, 0);
    run(1);
    check("p1_wr_req_after_1", fifo_wr_req, 1);
    check("p1_wr_data_after_1", fifo_wr_data, 5'h00);
    run(7);
    check("p1_out0", outstanding0, 4);
    check("p1_out1", outstanding1, 4);
    check("p1_got_size", got.size(), 7);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      w = got[i];
      check("p1_alt_src", w[4], i % 2);
    end

    // Phase 2: 3-beat locked group on src0 while src1 waits.
    do_reset();
    limit[0] = 3; grp[0] = 3;
    limit[1] = 2; grp[1] = 1;
    run(7);
    check("p2_got_size", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      w = got[i];
      check("p2_src_order", w[4], (i < 3) ? 0 : 1);
    end
    check("p2_trunc", burst_trunc, 0);

    // Phase 3: src1 sends beats without last -> forced release after 4 beats.
    do_reset();
    limit[0] = 0; grp[0] = 1;
    limit[1] = 6; grp[1] = 100;
    run(1);
    limit[0] = 2;
    run(10);
    check("p3_trunc", burst_trunc, 1);
    check("p3_got_size", got.size(), 7);
    if (got.size() >= 6) begin
      w = got[3]; check("p3_beat4_src", w[4], 1);
      w = got[4]; check("p3_after_release_src", w[4], 0);
      w = got[5]; check("p3_relock_src", w[4], 1);
    end
    check("p3_lock_holds_ready0", req0_ready, 0);

    // Phase 4: quota0=2 blocks src0 until a pop returns a credit.
    do_reset();
    quota0 = 8'd2;
    limit[0] = 5;
    run(6);
    check("p4_out0_at_quota", outstanding0, 2);
    check("p4_ready0_blocked", req0_ready, 0);
    check("p4_got_size", got.size(), 2);
    fifo_pop = 1'b1; fifo_pop_src = 1'b0;
    run(1);
    fifo_pop = 1'b0;
    check("p4_out0_after_pop", outstanding0, 1);
    run(1);
    check("p4_out0_refill", outstanding0, 2);
    run(2);
    check("p4_got_size_after", got.size(), 3);
    quota0 = 8'd128;

    // Phase 5: FIFO backpressure for 5 cycles mid-stream.
    do_reset();
    limit[0] = 1000; limit[1] = 1000;
    run(3);
    fifo_wr_ready = 1'b0;
    w = fifo_wr_data;
    check("p5_held_src", w[4], 0);
    for (int i = 0; i < 5; i++) begin
      drive_inputs(); #1;
      check("p5_stall_ready0", req0_ready, 0);
      check("p5_stall_ready1", req1_ready, 0);
      check("p5_stall_wr_req", fifo_wr_req, 1);
      check("p5_stall_data", fifo_wr_data, w);
      run(1);
    end
    fifo_wr_ready = 1'b1;
    run(4);
    check("p5_got_size", got.size(), 6);
    for (int i = 0; i < got.size(); i++) begin
      w = got[i];
      check("p5_alt_src", w[4], i % 2);
    end

    // Phase 6: fill to DEPTH, then pop and accept together on src0.
    do_reset();
    limit[0] = 1000; limit[1] = 1000;
    run(130);
    check("p6_full_out0", outstanding0, 64);
    check("p6_full_out1", outstanding1, 64);
    check("p6_full_ready0", req0_ready, 0);
    check("p6_full_ready1", req1_ready, 0);
    fifo_pop = 1'b1; fifo_pop_src = 1'b0;
    run(1);
    check("p6_pop_out0", outstanding0, 63);
    #1;
    check("p6_reopen_ready0", req0_ready, 1);
    run(1);
    check("p6_pop_accept_out0", outstanding0, 63);
    check("p6_pop_accept_out1", outstanding1, 64);
    fifo_pop = 1'b0;

    // Phase 7: reset asserted in the middle of a locked src1 burst.
    do_reset();
    limit[1] = 10; grp[1] = 100;
    run(2);
    reset_ = 1'b1;
    #1;
    check("p7_rst_wr_req", fifo_wr_req, 0);
    check("p7_rst_wr_data", fifo_wr_data, 0);
    check("p7_rst_out1", outstanding1, 0);
    check("p7_rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    reset_ = 1'b0;
    limit[0] = 10; grp[0] = 1;
    drive_inputs(); #1;
    check("p7_idle_ready0", req0_ready, 1);
    check("p7_idle_ready1", req1_ready, 0);
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
